// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC, a single-outstanding
// imem handshake, a one-word skid buffer and the IF/ID register.
module fetch_ctrl #(
  parameter int                           ADDR_WIDTH        = 32,
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]        RESET_PC          = 32'h00000000,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         o_imem_req,
  output logic [ADDR_WIDTH-1:0]        o_imem_addr,
  input  logic                         i_imem_ready,
  input  logic                         i_imem_rvalid,
  input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata,
  input  logic                         i_stall,
  input  logic                         i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        i_redirect_pc,
  output logic                         o_if_id_valid,
  output logic [ADDR_WIDTH-1:0]        o_if_id_pc,
  output logic [INSTRUCTION_WIDTH-1:0] o_if_id_instruction
);
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
  state_t                         r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0]          r_pc, w_pc_nx, r_skid_pc;
  logic [INSTRUCTION_WIDTH-1:0]   r_skid;
  logic                           r_kill, w_kill_nx;
  logic                           w_redir, w_accept, w_ifid_ld, w_skid_ld, w_from_skid;
  assign o_imem_req  = (r_state == REQ);
  assign o_imem_addr = r_pc;
  assign w_redir     = i_redirect_valid && (r_state != BOOT);
  assign w_accept    = !o_if_id_valid || !i_stall;
  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_kill_nx   = r_kill;
    w_ifid_ld   = 1'b0;
    w_skid_ld   = 1'b0;
    w_from_skid = 1'b0;
    unique case (r_state)
      BOOT: w_state_nx = REQ;
      REQ: if (i_imem_ready) begin
        w_state_nx = WAIT;
        w_kill_nx  = i_redirect_valid;
      end
      WAIT: if (i_imem_rvalid) begin
        w_kill_nx  = 1'b0;
        w_state_nx = REQ;
        if (!(r_kill || i_redirect_valid)) begin
          w_pc_nx    = r_pc + ADDR_WIDTH'(4);
          w_ifid_ld  = w_accept;
          w_skid_ld  = !w_accept;
          w_state_nx = w_accept ? REQ : HOLD;
        end
      end else if (i_redirect_valid) begin
        w_kill_nx = 1'b1;
      end
      HOLD: if (!i_stall) begin
        w_state_nx  = REQ;
        w_ifid_ld   = 1'b1;
        w_from_skid = 1'b1;
      end
      default: w_state_nx = BOOT;
    endcase
    // redirect overrides everything: new PC, nothing loads, skid is abandoned
    if (w_redir) begin
      w_pc_nx   = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      w_ifid_ld = 1'b0;
      w_skid_ld = 1'b0;
      if (r_state == HOLD) w_state_nx = REQ;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= BOOT;
      r_pc                <= RESET_PC;
      r_kill              <= 1'b0;
      r_skid              <= NOP_INSTR;
      r_skid_pc           <= '0;
      o_if_id_valid       <= 1'b0;
      o_if_id_pc          <= '0;
      o_if_id_instruction <= NOP_INSTR;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_kill  <= w_kill_nx;
      if (w_skid_ld) begin
        r_skid    <= i_imem_rdata;
        r_skid_pc <= r_pc;
      end
      if (w_redir) begin
        o_if_id_valid       <= 1'b0;
        o_if_id_instruction <= NOP_INSTR;
      end else if (w_ifid_ld) begin
        o_if_id_valid       <= 1'b1;
        o_if_id_pc          <= w_from_skid ? r_skid_pc : r_pc;
        o_if_id_instruction <= w_from_skid ? r_skid : i_imem_rdata;
      end else if (o_if_id_valid && !i_stall) begin
        o_if_id_valid       <= 1'b0;
        o_if_id_instruction <= NOP_INSTR;
      end
    end
  end
endmodule
